// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader
//   Program loader and run monitor for the cpu core. While the cpu is held in
//   reset, a host byte stream (valid/ready) is written into cpu memory at
//   addresses 0..DEPTH-1. The cpu is then held in reset for RST_HOLD more
//   cycles, released, and its instruction steps are counted until it halts or
//   the step budget runs out. Final PC, step count and pass/timeout are reported.
//
// Ports
//   clk, rst_                 clock, asynchronous active-low reset
//   start                     begin a load session (honoured in IDLE/DONE only)
//   in_valid/in_ready/in_data program byte stream; k-th accepted byte -> addr k
//   max_cycles, exp_pc        step budget and expected halt PC, sampled on RUN entry
//   mem_we/mem_addr/mem_wdata cpu memory write port (combinational from LOAD)
//   cpu_rst_                  active-low reset to the cpu (registered)
//   cpu_step, cpu_halt, cpu_pc cpu status inputs
//   busy, done, pass, timeout, final_pc, steps   registered status/results
module cpu_prog_loader #(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 16,
    parameter int RST_HOLD = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [ADDR_W-1:0] exp_pc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_,
    input  logic              cpu_step,
    input  logic              cpu_halt,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ADDR_W-1:0] final_pc,
    output logic [CNT_W-1:0]  steps
);

    // hold_q counts 0..RST_HOLD-1 while in RELEASE
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    max_q, max_d;
    logic [CNT_W-1:0]    steps_q, steps_d;
    logic [ADDR_W-1:0]   exp_q, exp_d;
    logic [ADDR_W-1:0]   final_pc_q, final_pc_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Write port is combinational so each accepted byte lands in the same cycle.
    assign in_ready  = (state_q == S_LOAD);
    assign mem_we    = in_ready && in_valid;
    assign mem_addr  = addr_q;
    assign mem_wdata = in_data;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        max_d      = max_q;
        steps_d    = steps_q;
        exp_d      = exp_q;
        final_pc_d = final_pc_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    addr_d     = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    final_pc_d = '0;
                    steps_d    = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        addr_d  = '0;
                        hold_d  = '0;
                        state_d = S_RELEASE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d = S_RUN;
                    steps_d = '0;
                    max_d   = max_cycles;
                    exp_d   = exp_pc;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                // Halt wins over timeout; neither counts a step in that cycle,
                // which keeps steps from ever passing the budget.
                if (cpu_halt) begin
                    state_d    = S_DONE;
                    pass_d     = (cpu_pc == exp_q);
                    final_pc_d = cpu_pc;
                end else if (steps_q == max_q) begin
                    state_d    = S_DONE;
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                    final_pc_d = cpu_pc;
                end else if (cpu_step) begin
                    steps_d = steps_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        busy_d    = (state_d == S_LOAD) || (state_d == S_RELEASE) || (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
        cpu_rst_d = (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            hold_q     <= '0;
            max_q      <= '0;
            steps_q    <= '0;
            exp_q      <= '0;
            final_pc_q <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cpu_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            max_q      <= max_d;
            steps_q    <= steps_d;
            exp_q      <= exp_d;
            final_pc_q <= final_pc_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cpu_rst_ = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign final_pc = final_pc_q;
    assign steps    = steps_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Self-checking bench for cpu_prog_loader. A small cpu stand-in produces one
// step strobe every second clock once released, and halts at a programmed
// step count with a programmed PC.
module tb_cpu_prog_loader;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [15:0] max_cycles = '0;
    logic [4:0]  exp_pc = '0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rst_;
    logic        cpu_step;
    logic        cpu_halt;
    logic [4:0]  cpu_pc;
    logic        busy, done, pass, timeout;
    logic [4:0]  final_pc;
    logic [15:0] steps;

    int n_cmp = 0;
    int n_bad = 0;

    int         halt_after = -1;   // -1: never halts
    logic [4:0] halt_pc = '0;
    int         nsteps = 0;
    logic       div = 1'b0;
    logic [7:0] img [32];
    logic [4:0] wr_addr [$];
    logic [7:0] wr_data [$];

    always #5 clk = ~clk;

    cpu_prog_loader #(
        .DEPTH(32), .ADDR_W(5), .DATA_W(8), .CNT_W(16), .RST_HOLD(5)
    ) dut (
        .clk(clk), .rst_(rst_), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .max_cycles(max_cycles), .exp_pc(exp_pc),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_(cpu_rst_), .cpu_step(cpu_step), .cpu_halt(cpu_halt), .cpu_pc(cpu_pc),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .final_pc(final_pc), .steps(steps)
    );

    assign cpu_halt = (halt_after >= 0) && (nsteps >= halt_after);
    assign cpu_step = cpu_rst_ && div && !cpu_halt;
    assign cpu_pc   = cpu_halt ? halt_pc : nsteps[4:0];

    always @(posedge clk) begin
        if (!cpu_rst_) begin
            div    <= 1'b0;
            nsteps <= 0;
        end else begin
            div <= ~div;
            if (cpu_step) nsteps <= nsteps + 1;
        end
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_img(input int seed, input int mult);
        for (int i = 0; i < 32; i++) img[i] = 8'(seed + i * mult);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Entered and left on a falling edge; byte i is offered for the next rising edge.
    task automatic load(input string t, input int nbytes, input bit gap);
        int i = 0;
        int cyc = 0;
        while (i < nbytes && cyc < 500) begin
            if (gap && (cyc % 3 == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = img[i];
                if (in_ready) i++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (cyc >= 500) chk({t, "_load_bound"}, i, nbytes);
    endtask

    task automatic chk_writes(input string t, input int nbytes);
        int bad = 0;
        chk({t, "_wr_cnt"}, wr_addr.size(), nbytes);
        for (int i = 0; i < nbytes && i < wr_addr.size(); i++)
            if (wr_addr[i] !== 5'(i) || wr_data[i] !== img[i]) bad++;
        chk({t, "_wr_order"}, bad, 0);
    endtask

    task automatic session(input string t, input int seed, input int mult, input bit gap,
                           input logic [4:0] ep, input logic [4:0] hpc, input int hafter,
                           input logic [15:0] mx, input bit poke,
                           input bit e_pass, input bit e_to,
                           input logic [4:0] e_fpc, input logic [15:0] e_steps);
        int lowcnt = 0;
        int cyc = 0;
        fill_img(seed, mult);
        halt_after = hafter;
        halt_pc    = hpc;
        exp_pc     = ep;
        max_cycles = mx;
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        chk({t, "_clr"}, {busy, done, pass, timeout, cpu_rst_, final_pc, steps}, {5'b10000, 5'd0, 16'd0});
        load(t, 32, gap);
        chk_writes(t, 32);
        chk({t, "_rel_rdy"}, in_ready, 1'b0);
        while (!cpu_rst_ && lowcnt < 50) begin
            lowcnt++;
            @(negedge clk);
        end
        chk({t, "_rst_hold"}, lowcnt, 5);
        if (poke) begin
            pulse_start();
            chk({t, "_start_ign"}, {busy, cpu_rst_, done}, 3'b110);
        end
        while (!done && cyc < 20000) begin
            cyc++;
            @(negedge clk);
        end
        chk({t, "_done"}, done, 1'b1);
        chk({t, "_pass"}, pass, e_pass);
        chk({t, "_timeout"}, timeout, e_to);
        chk({t, "_final_pc"}, final_pc, e_fpc);
        chk({t, "_steps"}, steps, e_steps);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", {busy, done, pass, timeout, cpu_rst_, in_ready, mem_we},
            7'b0);
        chk("rst_final_pc", final_pc, 5'd0);
        chk("rst_steps", steps, 16'd0);
        rst_ = 1'b1;
        @(negedge clk);
        chk("idle_rdy", in_ready, 1'b0);

        // CPUtest1-like image: halts at 0x17 after 20 steps
        session("t1", 8'h10, 3, 0, 5'h17, 5'h17, 20, 16'd3000, 0, 1, 0, 5'h17, 16'd20);
        repeat (5) @(negedge clk);
        chk("t1_hold", {done, cpu_rst_, steps}, {2'b11, 16'd20});

        session("t2a", 8'hA5, 7, 0, 5'h10, 5'h10, 7, 16'd3000, 0, 1, 0, 5'h10, 16'd7);
        session("t2b", 8'h01, 1, 0, 5'h0C, 5'h0C, 40, 16'd8000, 0, 1, 0, 5'h0C, 16'd40);

        // gapped stream, and halt at a PC other than the expected one
        session("t3", 8'h3C, 5, 1, 5'h06, 5'h05, 9, 16'd3000, 0, 0, 0, 5'h05, 16'd9);

        // never halts: budget of 100 steps, PC at timeout is 100 mod 32 = 4
        session("t4", 8'hC3, 0, 0, 5'h00, 5'h00, -1, 16'd100, 0, 0, 1, 5'h04, 16'd100);
        session("t4z", 8'h55, 2, 0, 5'h00, 5'h00, -1, 16'd0, 0, 0, 1, 5'h00, 16'd0);

        // start pulsed during RUN must not restart anything
        session("t5", 8'h77, 11, 0, 5'h1F, 5'h1F, 30, 16'd3000, 1, 1, 0, 5'h1F, 16'd30);

        // reset in the middle of a load, after 10 bytes
        fill_img(8'h20, 1);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        load("t6", 10, 0);
        chk_writes("t6a", 10);
        in_valid = 1'b1;
        #2 rst_ = 1'b0;
        #1;
        chk("t6_async", {busy, cpu_rst_, in_ready, mem_we, done}, 5'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_ = 1'b1;
        session("t6b", 8'h90, 13, 0, 5'h02, 5'h02, 3, 16'd3000, 0, 1, 0, 5'h02, 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
